axi_sram_bridge: RTL and testbench

//  AXI3 slave endpoint that sits directly downstream of the shared-master AXI mux and

---
 rtl/axi_defs_pkg.sv | 25 ++
 rtl/axi_addr_gen.sv | 43 ++++
 rtl/axi_sram_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_axi_sram_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_defs_pkg.sv
// Shared AXI encodings, FSM state type and read-FIFO metadata for the SRAM bridge.
package axi_defs_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_WRESP  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_RDRAIN = 3'd4
  } state_t;

  // Per-beat sideband carried alongside read data through the pipe and FIFO.
  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } rmeta_t;

endpackage

// File: rtl/axi_addr_gen.sv
// Beat address sequencer: next beat address for FIXED/INCR/WRAP, range check of
// the current beat, and detection of WRAP lengths AXI does not allow.
module axi_addr_gen
  import axi_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_AW     = 10,
  parameter int OFF        = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  oor,
  output logic                  wrap_bad
);

  logic [ADDR_WIDTH-1:0] step, span, mask, incr_addr;

  assign step      = ADDR_WIDTH'(1) << size;
  // Wrap container is the whole burst footprint, always a power of two when legal.
  assign span      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
  assign mask      = span - ADDR_WIDTH'(1);
  assign incr_addr = addr + step;

  // Anything above the SRAM window is out of range.
  assign oor      = |addr[ADDR_WIDTH-1:MEM_AW+OFF];
  assign wrap_bad = (burst == BURST_WRAP) &&
                    !(len inside {LEN_WIDTH'(1), LEN_WIDTH'(3), LEN_WIDTH'(7), LEN_WIDTH'(15)});

  // Select the following beat address by burst type.
  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr_addr & mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// AXI3 slave that serves one burst at a time onto a single-port 1-cycle SRAM.
// Reads stream through a 2-entry output FIFO with a credit check so a
// continuously ready master sees one beat per cycle.
module axi_sram_bridge
  import axi_defs_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_AW     = 10,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [LEN_WIDTH-1:0]  s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_WIDTH-1:0]   s_wid,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [LEN_WIDTH-1:0]  s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  mem_en,
  output logic [STRB_WIDTH-1:0] mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OFF = $clog2(STRB_WIDTH);

  state_t state_q, state_d;
  logic                  run_q, rr_last_write;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [LEN_WIDTH-1:0]  len_q, cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  werr_q, beat_oor, wrap_bad, beat_err, last_beat;
  logic                  aw_hs, ar_hs, w_hs, r_pop, rd_issue, idle;
  logic [2:0]            occ;

  logic                  inflight_q, pend_err_q;
  rmeta_t                pend_meta_q, push_meta;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0][DATA_WIDTH-1:0] f_data;
  rmeta_t [1:0]          f_meta;
  logic [1:0]            fifo_cnt;

  // Write ID is not needed: AXI3 write data arrives in order for the one open burst.
  logic unused_wid;
  assign unused_wid = ^s_wid;

  axi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .MEM_AW(MEM_AW), .OFF(OFF)
  ) u_addr_gen (
    .addr(addr_q), .size(size_q), .len(len_q), .burst(burst_q),
    .next_addr(next_addr), .oor(beat_oor), .wrap_bad(wrap_bad)
  );

  assign beat_err  = beat_oor | wrap_bad;
  assign last_beat = (cnt_q == len_q);

  // run_q keeps both address readies low through reset and its first cycle out.
  assign idle      = (state_q == ST_IDLE) && run_q;
  assign s_awready = idle && (!s_arvalid || !rr_last_write);
  assign s_arready = idle && (!s_awvalid ||  rr_last_write);
  assign aw_hs     = s_awvalid && s_awready;
  assign ar_hs     = s_arvalid && s_arready;

  assign s_wready  = (state_q == ST_WDATA);
  assign w_hs      = s_wvalid && s_wready;
  assign s_bvalid  = (state_q == ST_WRESP);
  assign s_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign s_bid     = id_q;

  assign s_rid     = id_q;
  assign s_rvalid  = (fifo_cnt != 2'd0);
  assign s_rdata   = f_data[0];
  assign s_rresp   = f_meta[0].resp;
  assign s_rlast   = f_meta[0].last;
  assign r_pop     = s_rvalid && s_rready;

  // Credit counts the beat leaving this cycle, which is what makes streaming bubble-free.
  assign occ      = 3'(fifo_cnt) + 3'(inflight_q) - 3'(r_pop);
  assign rd_issue = (state_q == ST_RDATA) && (occ < 3'd2);

  assign mem_en    = (w_hs || rd_issue) && !beat_err;
  assign mem_we    = (w_hs && !beat_err) ? s_wstrb : '0;
  assign mem_addr  = addr_q[OFF +: MEM_AW];
  assign mem_wdata = s_wdata;

  // Burst sequencing: IDLE -> WDATA -> WRESP, or IDLE -> RDATA -> RDRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (aw_hs) state_d = ST_WDATA;
                 else if (ar_hs) state_d = ST_RDATA;
      ST_WDATA:  if (w_hs && s_wlast) state_d = ST_WRESP;
      ST_WRESP:  if (s_bready) state_d = ST_IDLE;
      ST_RDATA:  if (rd_issue && last_beat) state_d = ST_RDRAIN;
      ST_RDRAIN: if (r_pop && s_rlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Burst context: latch on address handshake, step once per beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_q <= '0; addr_q <= '0; len_q <= '0; size_q <= '0;
      burst_q <= '0; cnt_q <= '0; werr_q <= 1'b0;
    end else if (aw_hs) begin
      id_q <= s_awid; addr_q <= s_awaddr; len_q <= s_awlen; size_q <= s_awsize;
      burst_q <= s_awburst; cnt_q <= '0; werr_q <= 1'b0;
    end else if (ar_hs) begin
      id_q <= s_arid; addr_q <= s_araddr; len_q <= s_arlen; size_q <= s_arsize;
      burst_q <= s_arburst; cnt_q <= '0; werr_q <= 1'b0;
    end else if (w_hs || rd_issue) begin
      addr_q <= next_addr;
      if (w_hs) werr_q <= werr_q | beat_err;
      if (rd_issue && !last_beat) cnt_q <= cnt_q + LEN_WIDTH'(1);
    end
  end

  // Arbitration history and post-reset ready enable.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q <= 1'b0;
      rr_last_write <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (state_q == ST_WRESP && s_bready)                rr_last_write <= 1'b1;
      else if (state_q == ST_RDRAIN && r_pop && s_rlast) rr_last_write <= 1'b0;
    end
  end

  // One-stage read pipe matching the SRAM latency.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q  <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_meta_q <= '0;
    end else begin
      inflight_q       <= rd_issue;
      pend_err_q       <= beat_err;
      pend_meta_q.resp <= beat_err ? RESP_SLVERR : RESP_OKAY;
      pend_meta_q.last <= last_beat;
    end
  end

  assign push_data = pend_err_q ? '0 : mem_rdata;
  assign push_meta = pend_meta_q;

  // Output FIFO: slot 0 is the head presented on R and only moves on a pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      f_data   <= '0;
      f_meta   <= '0;
      fifo_cnt <= 2'd0;
    end else begin
      if (r_pop) begin
        f_data[0] <= (fifo_cnt == 2'd2) ? f_data[1] : push_data;
        f_meta[0] <= (fifo_cnt == 2'd2) ? f_meta[1] : push_meta;
        if (inflight_q && fifo_cnt == 2'd2) begin
          f_data[1] <= push_data;
          f_meta[1] <= push_meta;
        end
      end else if (inflight_q) begin
        if (fifo_cnt == 2'd0) begin
          f_data[0] <= push_data;
          f_meta[0] <= push_meta;
        end else begin
          f_data[1] <= push_data;
          f_meta[1] <= push_meta;
        end
      end
      fifo_cnt <= fifo_cnt + 2'(inflight_q) - 2'(r_pop);
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Scoreboard bench for axi_sram_bridge: stimulus pushes expected B/R responses,
// a monitor pops and compares on every handshake; an SRAM model logs writes.
module tb_axi_sram_bridge;
  import axi_defs_pkg::*;

  localparam int IDW = 4, AW = 32, DW = 32, LW = 8, MAW = 10, SW = DW / 8;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic [IDW-1:0] s_awid, s_wid, s_bid, s_arid, s_rid;
  logic [AW-1:0]  s_awaddr, s_araddr;
  logic [LW-1:0]  s_awlen, s_arlen;
  logic [2:0]     s_awsize, s_arsize;
  logic [1:0]     s_awburst, s_arburst, s_bresp, s_rresp;
  logic           s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic           s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [DW-1:0]  s_wdata, s_rdata, mem_wdata, mem_rdata;
  logic [SW-1:0]  s_wstrb, mem_we;
  logic           mem_en;
  logic [MAW-1:0] mem_addr;

  axi_sram_bridge #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_AW(MAW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 aclk = ~aclk;

  int total = 0, bad = 0, cyc = 0;
  bit rr_mode = 1'b0;
  always @(posedge aclk) cyc <= cyc + 1;

  // SRAM model: preload a known pattern, byte-enabled writes, 1-cycle reads.
  logic [DW-1:0] mem [0:(1<<MAW)-1];
  logic init_done = 1'b0;
  int wlog[$];
  always @(posedge aclk) begin
    if (!init_done) begin
      for (int i = 0; i < (1<<MAW); i++) mem[i] <= 32'hDEAD0000 | i;
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we != '0) begin
        for (int b = 0; b < SW; b++)
          if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        wlog.push_back(int'(mem_addr));
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } bexp_t;
  rexp_t exp_r[$];
  bexp_t exp_b[$];
  int rhs_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++; bad++;
    $display("FAIL %s: got no handshake want handshake within bound", name);
  endtask

  task automatic push_r(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    rexp_t e;
    e.data = d; e.resp = r; e.last = l; e.id = id;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [IDW-1:0] id, input logic [1:0] r);
    bexp_t e;
    e.resp = r; e.id = id;
    exp_b.push_back(e);
  endtask

  // Monitor: compare on every R/B handshake, and check R is held while stalled.
  initial begin
    rexp_t er; bexp_t eb;
    logic held; logic [DW+2:0] snap;
    held = 1'b0; snap = '0;
    forever begin
      @(negedge aclk);
      if (held && aresetn) chk("r_hold", {s_rvalid, s_rdata, s_rresp, s_rlast}, {1'b1, snap});
      held = 1'b0;
      if (s_rvalid && s_rready) begin
        if (exp_r.size() == 0) timeout_fail("r_unexpected_beat");
        else begin
          er = exp_r.pop_front();
          chk("r_data", s_rdata, er.data);
          chk("r_resp", s_rresp, er.resp);
          chk("r_last", s_rlast, er.last);
          chk("r_id",   s_rid,   er.id);
          rhs_cyc.push_back(cyc);
        end
      end else if (s_rvalid) begin
        held = 1'b1;
        snap = {s_rdata, s_rresp, s_rlast};
      end
      if (s_bvalid && s_bready) begin
        if (exp_b.size() == 0) timeout_fail("b_unexpected");
        else begin
          eb = exp_b.pop_front();
          chk("b_resp", s_bresp, eb.resp);
          chk("b_id",   s_bid,   eb.id);
        end
      end
    end
  end

  // R ready: steady high, or toggling every cycle when rr_mode is set.
  initial begin
    s_rready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      s_rready = rr_mode ? ~s_rready : 1'b1;
    end
  end

  task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [1:0] bu);
    int n = 0;
    s_awid = id; s_awaddr = a; s_awlen = l; s_awsize = 3'd2; s_awburst = bu; s_awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!s_awready && n < 50);
    if (!s_awready) timeout_fail("aw_ready");
    @(posedge aclk); #1 s_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [1:0] bu);
    int n = 0;
    s_arid = id; s_araddr = a; s_arlen = l; s_arsize = 3'd2; s_arburst = bu; s_arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!s_arready && n < 50);
    if (!s_arready) timeout_fail("ar_ready");
    @(posedge aclk); #1 s_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] st, input logic l);
    int n = 0;
    s_wdata = d; s_wstrb = st; s_wlast = l; s_wvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!s_wready && n < 50);
    if (!s_wready) timeout_fail("w_ready");
    @(posedge aclk); #1 s_wvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [1:0] bu, input logic [DW-1:0] base, input logic [SW-1:0] st);
    send_aw(id, a, l, bu);
    for (int i = 0; i <= int'(l); i++) send_w(base + DW'(i), st, i == int'(l));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin @(posedge aclk); n++; end
    if (exp_r.size() != 0 || exp_b.size() != 0) timeout_fail("drain");
    exp_r.delete(); exp_b.delete();
    @(posedge aclk); #1;
  endtask

  // Drive both address channels together and check which one the bridge grants.
  task automatic tie(input logic exp_aw, input logic [IDW-1:0] wid_, input logic [IDW-1:0] rid_);
    s_awid = wid_; s_awaddr = 32'h10; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = BURST_INCR;
    s_arid = rid_; s_araddr = 32'h10; s_arlen = 8'd3; s_arsize = 3'd2; s_arburst = BURST_INCR;
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge aclk);
    chk("tie_awready", s_awready, exp_aw);
    chk("tie_arready", s_arready, !exp_aw);
    @(posedge aclk); #1 s_awvalid = 1'b0; s_arvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int wexp[4];
    wexp = '{7, 4, 5, 6};
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk); #1;
    chk("rst_ready", {s_awready, s_arready, s_wready}, 0);
    chk("rst_valid", {s_bvalid, s_rvalid}, 0);
    chk("rst_mem",   {mem_en, mem_we, mem_addr}, 0);
    chk("rst_resp",  {s_bresp, s_rresp, s_bid, s_rid}, 0);
    chk("rst_rdata", s_rdata, 0);
    @(negedge aclk) aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // Tie after reset goes to write; INCR write of 4 words at 0x10
    push_b(4'd1, RESP_OKAY);
    tie(1'b1, 4'd1, 4'd2);
    for (int i = 0; i < 4; i++) send_w(32'hA0000000 + DW'(i), 4'hF, i == 3);
    wait_drain();
    for (int i = 0; i < 4; i++) chk("incr_mem", mem[4+i], 32'hA0000000 + DW'(i));
    // Next tie goes to read; read back the same words
    for (int i = 0; i < 4; i++) push_r(4'd2, 32'hA0000000 + DW'(i), RESP_OKAY, i == 3);
    tie(1'b0, 4'd3, 4'd2);
    wait_drain();

    // WRAP len=3 from 0x1C visits words 7,4,5,6
    wlog.delete();
    push_b(4'd3, RESP_OKAY);
    write_burst(4'd3, 32'h1C, 8'd3, BURST_WRAP, 32'hB0000000, 4'hF);
    wait_drain();
    chk("wrap_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < wlog.size()) chk("wrap_addr", wlog[i], wexp[i]);
    chk("wrap_mem7", mem[7], 32'hB0000000);
    chk("wrap_mem6", mem[6], 32'hB0000003);
    // Illegal WRAP length: SLVERR, nothing written
    wlog.delete();
    push_b(4'd4, RESP_SLVERR);
    write_burst(4'd4, 32'h20, 8'd2, BURST_WRAP, 32'hC0000000, 4'hF);
    wait_drain();
    chk("wrapbad_nwr", wlog.size(), 0);
    chk("wrapbad_mem", mem[8], 32'hDEAD0008);

    // 8-beat read, first with a stalling master, then streaming
    push_b(4'd5, RESP_OKAY);
    write_burst(4'd5, 32'h40, 8'd7, BURST_INCR, 32'hD0000000, 4'hF);
    wait_drain();
    for (int i = 0; i < 8; i++) push_r(4'd6, 32'hD0000000 + DW'(i), RESP_OKAY, i == 7);
    rr_mode = 1'b1;
    send_ar(4'd6, 32'h40, 8'd7, BURST_INCR);
    wait_drain();
    rr_mode = 1'b0;
    repeat (2) @(posedge aclk); #1;
    rhs_cyc.delete();
    for (int i = 0; i < 8; i++) push_r(4'd7, 32'hD0000000 + DW'(i), RESP_OKAY, i == 7);
    send_ar(4'd7, 32'h40, 8'd7, BURST_INCR);
    wait_drain();
    chk("stream_beats", rhs_cyc.size(), 8);
    if (rhs_cyc.size() == 8) chk("stream_span", rhs_cyc[7] - rhs_cyc[0], 7);

    // Out-of-range read, partial-strobe write, out-of-range write
    push_r(4'd8, 32'h0, RESP_SLVERR, 1'b0);
    push_r(4'd8, 32'h0, RESP_SLVERR, 1'b1);
    send_ar(4'd8, 32'h1000, 8'd1, BURST_INCR);
    wait_drain();
    push_b(4'd9, RESP_OKAY);
    write_burst(4'd9, 32'h8, 8'd0, BURST_INCR, 32'hAABBCCDD, 4'h3);
    wait_drain();
    chk("strb_mem", mem[2], 32'hDEADCCDD);
    push_r(4'd10, 32'hDEADCCDD, RESP_OKAY, 1'b1);
    send_ar(4'd10, 32'h8, 8'd0, BURST_INCR);
    wait_drain();
    push_b(4'd11, RESP_SLVERR);
    write_burst(4'd11, 32'h2000, 8'd0, BURST_INCR, 32'h12345678, 4'hF);
    wait_drain();

    // Reset in the middle of a write burst, then a clean burst
    send_aw(4'd12, 32'h80, 8'd3, BURST_INCR);
    send_w(32'hE0000000, 4'hF, 1'b0);
    s_wdata = 32'hE0000001; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_ready", {s_awready, s_arready, s_wready}, 0);
    chk("midrst_valid", {s_bvalid, s_rvalid}, 0);
    chk("midrst_mem",   {mem_en, mem_we}, 0);
    s_wvalid = 1'b0;
    repeat (2) @(posedge aclk); #1;
    chk("midrst_nobeat2", mem[33], 32'hDEAD0021);
    @(negedge aclk) aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;
    push_b(4'd13, RESP_OKAY);
    write_burst(4'd13, 32'h80, 8'd3, BURST_INCR, 32'hF0000000, 4'hF);
    wait_drain();
    for (int i = 0; i < 4; i++) chk("postrst_mem", mem[32+i], 32'hF0000000 + DW'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
